// File: rtl/ball_motion.sv
// Ball motion engine: serve/fly/lost life cycle, bounce-driven reflection
// and per-tick position update with playfield saturation.
module ball_motion #(
    parameter int unsigned RADIUS  = 4,
    parameter int unsigned SPEED   = 2,
    parameter int unsigned SERVE_Y = 436,
    parameter int unsigned BOTTOM  = 479,
    parameter int unsigned MAX_X   = 639
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    input  logic       bounced,
    input  logic [1:0] direction,
    output logic [9:0] b_x,
    output logic [9:0] b_y,
    output logic [5:0] b_radius,
    output logic       moving,
    output logic       hit,
    output logic       lost
);

    localparam int unsigned XW = 10;
    localparam int unsigned AW = 11;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_FLY  = 2'd1;
    localparam logic [1:0] S_LOST = 2'd2;

    // Pending flag bit positions follow the direction encoding
    localparam int unsigned P_UP = 0;
    localparam int unsigned P_RT = 1;
    localparam int unsigned P_DN = 2;
    localparam int unsigned P_LT = 3;

    localparam logic [AW-1:0] C_SPEED  = AW'(SPEED);
    localparam logic [AW-1:0] C_RADIUS = AW'(RADIUS);
    localparam logic [AW-1:0] C_XMAX   = AW'(MAX_X - RADIUS);
    localparam logic [AW-1:0] C_BOTTOM = AW'(BOTTOM);
    localparam logic [XW-1:0] C_X_RST  = XW'(320);
    localparam logic [XW-1:0] C_SERVE  = XW'(SERVE_Y);
    localparam logic [XW-1:0] C_BOT_XW = XW'(BOTTOM);

    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [XW-1:0] r_y;
    logic          r_sx;
    logic          r_sy;
    logic [3:0]    r_pend;
    logic          r_moving;
    logic          r_hit;
    logic          r_lost;

    logic [1:0]    w_state_nx;
    logic [XW-1:0] w_x_nx;
    logic [XW-1:0] w_y_nx;
    logic          w_sx_nx;
    logic          w_sy_nx;
    logic [3:0]    w_pend_nx;
    logic          w_hit_nx;
    logic          w_lost_nx;

    logic [3:0]    w_pend_now;
    logic          w_sx_upd;
    logic          w_sy_upd;
    logic [AW-1:0] w_x_raw;
    logic [AW-1:0] w_y_raw;
    logic [XW-1:0] w_x_new;
    logic [AW-1:0] w_y_new;

    // Pending reflections including a bounce seen on this very cycle
    always_comb begin
        w_pend_now = r_pend;
        if (bounced) begin
            w_pend_now[direction] = 1'b1;
        end
    end

    // Signs after reflection: opposite flags on one axis cancel out
    always_comb begin
        w_sx_upd = r_sx;
        w_sy_upd = r_sy;
        if (w_pend_now[P_LT] && !w_pend_now[P_RT]) begin
            w_sx_upd = 1'b0;
        end else if (w_pend_now[P_RT] && !w_pend_now[P_LT]) begin
            w_sx_upd = 1'b1;
        end
        if (w_pend_now[P_UP] && !w_pend_now[P_DN]) begin
            w_sy_upd = 1'b0;
        end else if (w_pend_now[P_DN] && !w_pend_now[P_UP]) begin
            w_sy_upd = 1'b1;
        end
    end

    // 11-bit step so that a wrap below zero shows up in the top bit
    always_comb begin
        w_x_raw = w_sx_upd ? (AW'(r_x) + C_SPEED) : (AW'(r_x) - C_SPEED);
        w_y_raw = w_sy_upd ? (AW'(r_y) + C_SPEED) : (AW'(r_y) - C_SPEED);

        if ((!w_sx_upd && w_x_raw[AW-1]) || (w_x_raw < C_RADIUS)) begin
            w_x_new = XW'(C_RADIUS);
        end else if (w_x_raw > C_XMAX) begin
            w_x_new = XW'(C_XMAX);
        end else begin
            w_x_new = w_x_raw[XW-1:0];
        end

        if ((!w_sy_upd && w_y_raw[AW-1]) || (w_y_raw < C_RADIUS)) begin
            w_y_new = C_RADIUS;
        end else begin
            w_y_new = w_y_raw;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_sx_nx    = r_sx;
        w_sy_nx    = r_sy;
        w_pend_nx  = r_pend;
        w_hit_nx   = 1'b0;
        w_lost_nx  = 1'b0;

        case (r_state)
            S_HOLD: begin
                w_pend_nx = 4'b0;
                w_y_nx    = C_SERVE;
                if (tick) begin
                    w_x_nx = paddle_x;
                end
                if (launch) begin
                    w_state_nx = S_FLY;
                    w_sx_nx    = 1'b1;
                    w_sy_nx    = 1'b0;
                end
            end
            S_FLY: begin
                w_pend_nx = w_pend_now;
                if (tick) begin
                    w_sx_nx   = w_sx_upd;
                    w_sy_nx   = w_sy_upd;
                    w_hit_nx  = |w_pend_now;
                    w_pend_nx = 4'b0;
                    w_x_nx    = w_x_new;
                    if (w_y_new >= C_BOTTOM) begin
                        w_y_nx     = C_BOT_XW;
                        w_state_nx = S_LOST;
                        w_lost_nx  = 1'b1;
                    end else begin
                        w_y_nx = w_y_new[XW-1:0];
                    end
                end
            end
            S_LOST: begin
                w_pend_nx = 4'b0;
                if (launch) begin
                    w_state_nx = S_HOLD;
                    w_x_nx     = paddle_x;
                    w_y_nx     = C_SERVE;
                end
            end
            default: begin
                w_state_nx = S_HOLD;
                w_pend_nx  = 4'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_HOLD;
            r_x      <= C_X_RST;
            r_y      <= C_SERVE;
            r_sx     <= 1'b1;
            r_sy     <= 1'b0;
            r_pend   <= 4'b0;
            r_moving <= 1'b0;
            r_hit    <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_sx     <= w_sx_nx;
            r_sy     <= w_sy_nx;
            r_pend   <= w_pend_nx;
            r_moving <= (w_state_nx == S_FLY);
            r_hit    <= w_hit_nx;
            r_lost   <= w_lost_nx;
        end
    end

    assign b_x      = r_x;
    assign b_y      = r_y;
    assign b_radius = 6'(RADIUS);
    assign moving   = r_moving;
    assign hit      = r_hit;
    assign lost     = r_lost;

endmodule
